// File: rtl/cdu_pkg.sv
// Shared types for the CDU sample path: sequencer state encoding and resolver quadrant codes.
package cdu_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE    = 3'd0,
    SEQ_SETTLE  = 3'd1,
    SEQ_CAPTURE = 3'd2,
    SEQ_DRIVE   = 3'd3,
    SEQ_DONE    = 3'd4
  } seq_state_e;

  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  // Sign pair (sine, cosine) to quadrant: ++ 0, +- 1, -- 2, -+ 3.
  function automatic logic [1:0] quadOf(input logic sinPos, input logic cosPos);
    logic [1:0] q;
    case ({sinPos, cosPos})
      2'b11:   q = QUAD_0;
      2'b10:   q = QUAD_1;
      2'b00:   q = QUAD_2;
      default: q = QUAD_3;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector; a level already high when reset releases reads as a rise.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev <= 1'b0;
    else     r_prev <= i_level;
  end

  assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/iss_sample_sequencer.sv
// Per-interrogate resolver sampling: settle, capture quadrant/error sign, then issue
// rate-limited UP/DN pulses to the read counter until null, reversal or pulse budget.
module iss_sample_sequencer
  import cdu_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int MAX_PULSES = 16,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ISSIHI,
  input  logic             _51KPHI,
  input  logic             SINPOS,
  input  logic             COSPOS,
  input  logic             ERRPOS,
  input  logic             ERRNZ,
  output logic [1:0]       QUAD,
  output logic             SAMPLE_VALID,
  output logic             UP,
  output logic             DN,
  output logic             BUSY,
  output logic [CNT_W-1:0] PULSES,
  output logic             OVERRUN
);

  localparam int               SET_W       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(MAX_PULSES);

  seq_state_e       r_state;
  seq_state_e       w_stateNxt;
  logic             w_issRise;
  logic             w_tickRise;
  logic             w_start;
  logic             w_capture;
  logic             w_pulse;
  logic             w_done;
  logic             w_stop;
  logic [SET_W-1:0] r_settleCnt;
  logic [CNT_W-1:0] r_pulseCnt;
  logic             r_sign;
  logic [1:0]       r_quad;
  logic             r_sampleValid;
  logic             r_up;
  logic             r_dn;
  logic [CNT_W-1:0] r_pulses;
  logic             r_overrun;

  rise_detect u_issRise (
    .clk     (clk),
    .rst     (rst),
    .i_level (ISSIHI),
    .o_rise  (w_issRise)
  );

  rise_detect u_tickRise (
    .clk     (clk),
    .rst     (rst),
    .i_level (_51KPHI),
    .o_rise  (w_tickRise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= SEQ_IDLE;
    else     r_state <= w_stateNxt;
  end

  // Budget check comes first so a saturated counter ends the run even while the error persists.
  always_comb begin
    w_stateNxt = r_state;
    w_start    = 1'b0;
    w_capture  = 1'b0;
    w_pulse    = 1'b0;
    w_done     = 1'b0;
    w_stop     = (r_pulseCnt == CNT_MAX) || !ERRNZ || (ERRPOS != r_sign);
    case (r_state)
      SEQ_IDLE: begin
        if (w_issRise) begin
          w_start    = 1'b1;
          w_stateNxt = SEQ_SETTLE;
        end
      end
      SEQ_SETTLE: begin
        if (r_settleCnt == '0) w_stateNxt = SEQ_CAPTURE;
      end
      SEQ_CAPTURE: begin
        w_capture  = 1'b1;
        w_stateNxt = SEQ_DRIVE;
      end
      SEQ_DRIVE: begin
        if (w_tickRise) begin
          if (w_stop) w_stateNxt = SEQ_DONE;
          else        w_pulse    = 1'b1;
        end
      end
      SEQ_DONE: begin
        w_done     = 1'b1;
        w_stateNxt = SEQ_IDLE;
      end
      default: w_stateNxt = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_settleCnt   <= '0;
      r_pulseCnt    <= '0;
      r_sign        <= 1'b0;
      r_quad        <= QUAD_0;
      r_sampleValid <= 1'b0;
      r_up          <= 1'b0;
      r_dn          <= 1'b0;
      r_pulses      <= '0;
      r_overrun     <= 1'b0;
    end else begin
      r_sampleValid <= w_capture;
      r_up          <= w_pulse & r_sign;
      r_dn          <= w_pulse & ~r_sign;
      r_overrun     <= w_issRise & (r_state != SEQ_IDLE);
      if (w_start)
        r_settleCnt <= SETTLE_LOAD;
      else if ((r_state == SEQ_SETTLE) && (r_settleCnt != '0))
        r_settleCnt <= r_settleCnt - 1'b1;
      if (w_capture) begin
        r_quad     <= quadOf(SINPOS, COSPOS);
        r_sign     <= ERRPOS;
        r_pulseCnt <= '0;
      end else if (w_pulse) begin
        r_pulseCnt <= r_pulseCnt + 1'b1;
      end
      if (w_done) r_pulses <= r_pulseCnt;
    end
  end

  assign QUAD         = r_quad;
  assign SAMPLE_VALID = r_sampleValid;
  assign UP           = r_up;
  assign DN           = r_dn;
  assign BUSY         = (r_state != SEQ_IDLE);
  assign PULSES       = r_pulses;
  assign OVERRUN      = r_overrun;

endmodule

// File: tb/tb_iss_sample_sequencer.sv
// Random interrogate/tick/comparator traffic against a cycle-stamped event model,
// plus a mid-sequence reset check.
module tb_iss_sample_sequencer;

  localparam int SETTLE_CYC = 4;
  localparam int MAX_PULSES = 16;
  localparam int CNT_W      = 5;
  localparam int N          = 1200;
  localparam int TAIL       = 100;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic issihi = 1'b0, tick = 1'b0, sinPos = 1'b0, cosPos = 1'b0, errPos = 1'b0, errNz = 1'b0;
  logic [1:0]       quad;
  logic             sampleValid, up, dn, busy, overrun;
  logic [CNT_W-1:0] pulses;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int base  = 0;
  bit monEn = 1'b0;
  bit prevBusy = 1'b0;

  logic pIss[N], pTick[N], pSin[N], pCos[N], pErrpos[N], pErrnz[N];
  ev_t  svQ[$], pulseQ[$], ovQ[$], doneQ[$];

  iss_sample_sequencer #(
    .SETTLE_CYC (SETTLE_CYC),
    .MAX_PULSES (MAX_PULSES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ISSIHI       (issihi),
    ._51KPHI      (tick),
    .SINPOS       (sinPos),
    .COSPOS       (cosPos),
    .ERRPOS       (errPos),
    .ERRNZ        (errNz),
    .QUAD         (quad),
    .SAMPLE_VALID (sampleValid),
    .UP           (up),
    .DN           (dn),
    .BUSY         (busy),
    .PULSES       (pulses),
    .OVERRUN      (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int quadModel(input logic s, input logic c);
    if (s && c)   return 0;
    if (s && !c)  return 1;
    if (!s && !c) return 2;
    return 3;
  endfunction

  function automatic bit issRise(input int d);
    return pIss[d] && !(d > 0 ? pIss[d-1] : 1'b0);
  endfunction

  function automatic bit tickRise(input int d);
    return pTick[d] && !(d > 0 ? pTick[d-1] : 1'b0);
  endfunction

  task automatic genPlan();
    int d, segLen, hiLen, mode, ovAt, flipAt;
    logic sg;
    d = 0;
    while (d < N - TAIL) begin
      segLen = $urandom_range(40, 110);
      hiLen  = $urandom_range(1, 30);
      mode   = $urandom_range(0, 3);
      sg     = 1'($urandom_range(0, 1));
      ovAt   = ($urandom_range(0, 2) == 0) ? $urandom_range(hiLen + 2, hiLen + 14) : -10;
      flipAt = (mode == 3) ? $urandom_range(8, 40) : -1;
      for (int k = 0; k < segLen && d < N - TAIL; k++) begin
        pIss[d]    = (k >= 1 && k <= hiLen) || (k == ovAt) || (k == ovAt + 1);
        pTick[d]   = ($urandom_range(0, 2) == 0);
        pSin[d]    = 1'($urandom_range(0, 1));
        pCos[d]    = 1'($urandom_range(0, 1));
        pErrpos[d] = (flipAt >= 0 && k >= flipAt) ? ~sg : sg;
        case (mode)
          0:       pErrnz[d] = 1'b1;
          1:       pErrnz[d] = ($urandom_range(0, 15) != 0);
          2:       pErrnz[d] = 1'b0;
          default: pErrnz[d] = 1'b1;
        endcase
        d++;
      end
    end
    for (; d < N; d++) begin
      pIss[d]    = 1'b0;
      pTick[d]   = (d % 3 == 0);
      pSin[d]    = 1'($urandom_range(0, 1));
      pCos[d]    = 1'($urandom_range(0, 1));
      pErrpos[d] = 1'($urandom_range(0, 1));
      pErrnz[d]  = 1'b0;
    end
  endtask

  // Index d = value driven just after edge d; an output caused at edge e is seen at that negedge.
  task automatic buildExpect();
    int nextIdle, cap, cnt, doneEdge;
    logic sign;
    nextIdle = 1;
    for (int d = 0; d < N; d++) begin
      if (issRise(d)) begin
        if (d + 1 < nextIdle) begin
          ovQ.push_back('{d + 1, 1});
        end else begin
          cap  = d + SETTLE_CYC + 2;
          sign = pErrpos[cap-1];
          svQ.push_back('{cap, quadModel(pSin[cap-1], pCos[cap-1])});
          cnt      = 0;
          doneEdge = -1;
          for (int t = cap; t < N && doneEdge < 0; t++) begin
            if (tickRise(t)) begin
              if (cnt == MAX_PULSES || !pErrnz[t] || pErrpos[t] != sign) doneEdge = t + 1;
              else begin
                pulseQ.push_back('{t + 1, int'(sign)});
                cnt++;
              end
            end
          end
          doneQ.push_back('{doneEdge + 1, cnt});
          nextIdle = doneEdge + 2;
        end
      end
    end
  endtask

  task automatic applyStimulus();
    svQ.delete(); pulseQ.delete(); ovQ.delete(); doneQ.delete();
    genPlan();
    buildExpect();
    @(posedge clk);
    #1;
    base     = cyc;
    prevBusy = 1'b0;
    monEn    = 1'b1;
    for (int d = 0; d < N; d++) begin
      if (d > 0) begin
        @(posedge clk);
        #1;
      end
      issihi = pIss[d]; tick = pTick[d]; sinPos = pSin[d];
      cosPos = pCos[d]; errPos = pErrpos[d]; errNz = pErrnz[d];
    end
    @(posedge clk);
    #1;
    issihi = 1'b0; tick = 1'b0; errNz = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    monEn = 1'b0;
    checkOutput("SAMPLE_VALID events missing", svQ.size(), 0);
    checkOutput("UP/DN pulses missing", pulseQ.size(), 0);
    checkOutput("OVERRUN events missing", ovQ.size(), 0);
    checkOutput("sequence completions missing", doneQ.size(), 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " QUAD"}, int'(quad), 0);
    checkOutput({tag, " SAMPLE_VALID"}, int'(sampleValid), 0);
    checkOutput({tag, " UP"}, int'(up), 0);
    checkOutput({tag, " DN"}, int'(dn), 0);
    checkOutput({tag, " BUSY"}, int'(busy), 0);
    checkOutput({tag, " PULSES"}, int'(pulses), 0);
    checkOutput({tag, " OVERRUN"}, int'(overrun), 0);
  endtask

  always @(negedge clk) begin
    int e;
    ev_t ev;
    if (monEn) begin
      e = cyc - base;
      if (up || dn) begin
        checkOutput("UP and DN exclusive", int'(up & dn), 0);
        if (pulseQ.size() == 0) checkOutput("unexpected pulse at cycle", e, -1);
        else begin
          ev = pulseQ.pop_front();
          checkOutput("pulse cycle", e, ev.cyc);
          checkOutput("pulse UP", int'(up), ev.val);
          checkOutput("pulse DN", int'(dn), 1 - ev.val);
        end
      end
      if (sampleValid) begin
        if (svQ.size() == 0) checkOutput("unexpected SAMPLE_VALID at cycle", e, -1);
        else begin
          ev = svQ.pop_front();
          checkOutput("SAMPLE_VALID cycle", e, ev.cyc);
          checkOutput("QUAD", int'(quad), ev.val);
        end
      end
      if (overrun) begin
        if (ovQ.size() == 0) checkOutput("unexpected OVERRUN at cycle", e, -1);
        else begin
          ev = ovQ.pop_front();
          checkOutput("OVERRUN cycle", e, ev.cyc);
        end
      end
      if (prevBusy && !busy) begin
        if (doneQ.size() == 0) checkOutput("unexpected BUSY drop at cycle", e, -1);
        else begin
          ev = doneQ.pop_front();
          checkOutput("BUSY drop cycle", e, ev.cyc);
          checkOutput("PULSES", int'(pulses), ev.val);
        end
      end
      prevBusy = busy;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ups, guard;
    #1;
    checkAllZero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    applyStimulus();

    // Mid-drive reset: start a sequence, let five UP pulses out, then hit rst.
    sinPos = 1'b0; cosPos = 1'b1; errPos = 1'b1; errNz = 1'b1;
    @(posedge clk);
    #1;
    issihi = 1'b1;
    ups = 0;
    guard = 0;
    while (ups < 5 && guard < 400) begin
      @(posedge clk);
      #1;
      tick = ~tick;
      @(negedge clk);
      if (up) ups++;
      guard++;
    end
    checkOutput("pulses before reset", ups, 5);
    checkOutput("QUAD before reset", int'(quad), 3);
    checkOutput("BUSY before reset", int'(busy), 1);
    rst = 1'b1;
    #1;
    checkAllZero("mid-sequence reset");
    issihi = 1'b0; tick = 1'b0; errNz = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    applyStimulus();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
